// File: rtl/dmem_ctrl.sv
// dmem_ctrl: 256 x 32 byte-addressable data memory responder with wait states and a
// ready/busy handshake. Optional misalignment trap enabled by DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [9:0]  address_DMEM,
    input  logic [31:0] write_data_DMEM,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic [31:0] data_DMEM,
    output logic        mem_busy,
    output logic        mem_ready,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WAIT   = 2'b01,
        S_ACCESS = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    localparam logic [2:0] CNT_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   lane_mask = 4'b0001 << lo;
            2'b01:   lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Replicating the right-aligned data lets the lane mask alone pick the target bytes.
    function automatic logic [31:0] place_store(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   place_store = {4{wd[7:0]}};
            2'b01:   place_store = {2{wd[15:0]}};
            default: place_store = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] lo,
                                                input logic uns, input logic [31:0] word);
        logic [31:0] sh;
        case (size)
            2'b00: begin
                sh = word >> {lo, 3'b000};
                load_extend = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                sh = word >> {lo[1], 4'b0000};
                load_extend = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: begin
                sh = word;
                load_extend = sh;
            end
        endcase
    endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = lo[0];
            default: is_misaligned = (lo != 2'b00);
        endcase
    endfunction
`else
    function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   align_lane = lo;
            2'b01:   align_lane = {lo[1], 1'b0};
            default: align_lane = 2'b00;
        endcase
    endfunction
`endif

    state_t      state_r;
    logic [2:0]  cnt_r;
    logic [9:0]  addr_r;
    logic [31:0] wdata_r;
    logic [1:0]  size_r;
    logic        uns_r;
    logic        store_r;
    logic [31:0] mem_r [0:255];

    logic        req_s;
    logic        trap_s;
    logic        commit_s;
    logic [1:0]  lane_s;
    logic [3:0]  be_s;
    logic [31:0] wword_s;
    logic [31:0] rword_s;
    logic [31:0] load_s;

    // Decode the latched request into lane enables, store data and the extended load value.
    always_comb begin
        req_s = MemRead | MemWrite;
`ifdef DMEM_MISALIGN_TRAP_EN
        trap_s = is_misaligned(size_r, addr_r[1:0]);
        lane_s = addr_r[1:0];
`else
        trap_s = 1'b0;
        lane_s = align_lane(size_r, addr_r[1:0]);
`endif
        be_s     = lane_mask(size_r, lane_s);
        wword_s  = place_store(size_r, wdata_r);
        rword_s  = mem_r[addr_r[9:2]];
        load_s   = load_extend(size_r, lane_s, uns_r, rword_s);
        commit_s = (state_r == S_ACCESS) && store_r && !trap_s;
    end

    // Byte-lane write port; the RAM is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (commit_s && RSTn) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[addr_r[9:2]][8*i +: 8] <= wword_s[8*i +: 8];
                end
            end
        end
    end

    // Access sequencer with registered handshake outputs and load result.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r   <= S_IDLE;
            cnt_r     <= 3'd0;
            addr_r    <= 10'd0;
            wdata_r   <= 32'd0;
            size_r    <= 2'b00;
            uns_r     <= 1'b0;
            store_r   <= 1'b0;
            data_DMEM <= 32'd0;
            mem_busy  <= 1'b0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    mem_ready <= 1'b0;
                    mem_err   <= 1'b0;
                    if (req_s) begin
                        addr_r   <= address_DMEM;
                        wdata_r  <= write_data_DMEM;
                        size_r   <= mem_size;
                        uns_r    <= mem_unsigned;
                        store_r  <= MemWrite;
                        cnt_r    <= CNT_LOAD;
                        mem_busy <= 1'b1;
                        state_r  <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_r == 3'd0) begin
                        state_r <= S_ACCESS;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                S_ACCESS: begin
                    state_r   <= S_DONE;
                    mem_busy  <= 1'b0;
                    mem_ready <= 1'b1;
                    mem_err   <= trap_s;
                    if (!store_r) begin
                        data_DMEM <= trap_s ? 32'd0 : load_s;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: one instance with WAIT_STATES = 1 for
// functional scenarios, one with WAIT_STATES = 0 for back-to-back throughput.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          errors = 0;
    int          checks = 0;

    logic        rd, wr, uns;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic [31:0] data;
    logic        busy, ready, err;

    logic        rd0, wr0, uns0;
    logic [9:0]  addr0;
    logic [31:0] wd0;
    logic [1:0]  sz0;
    logic [31:0] data0;
    logic        busy0, ready0, err0;

    always #5 clk = ~clk;

    dmem_ctrl #(.WAIT_STATES(1)) dut (
        .CLK(clk), .RSTn(rst_n), .MemRead(rd), .MemWrite(wr), .address_DMEM(addr),
        .write_data_DMEM(wd), .mem_size(sz), .mem_unsigned(uns),
        .data_DMEM(data), .mem_busy(busy), .mem_ready(ready), .mem_err(err)
    );

    dmem_ctrl #(.WAIT_STATES(0)) dut0 (
        .CLK(clk), .RSTn(rst_n), .MemRead(rd0), .MemWrite(wr0), .address_DMEM(addr0),
        .write_data_DMEM(wd0), .mem_size(sz0), .mem_unsigned(uns0),
        .data_DMEM(data0), .mem_busy(busy0), .mem_ready(ready0), .mem_err(err0)
    );

    // One access on the WAIT_STATES=1 instance; lat = negedges from request edge to ready (0 = timeout).
    task automatic access(input logic w, input logic r, input logic [9:0] a, input logic [31:0] d,
                          input logic [1:0] s, input logic u,
                          output logic [31:0] rdata, output logic rerr, output int lat);
        @(negedge clk);
        wr = w; rd = r; addr = a; wd = d; sz = s; uns = u;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; addr = 10'h3FF; wd = 32'hFFFF_FFFF;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ready) begin
                lat = n;
                break;
            end
        end
        rdata = data;
        rerr = err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rd = 1'b0; wr = 1'b0; addr = 10'd0; wd = 32'd0; sz = 2'b10; uns = 1'b0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = 10'd0; wd0 = 32'd0; sz0 = 2'b10; uns0 = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 00000000", data); end
        checks++; if ({busy, ready, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, ready, err}); end
        checks++; if ({busy0, ready0, err0, data0} !== 35'd0) begin errors++; $display("FAIL reset_dut0: got %h want 0", {busy0, ready0, err0, data0}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        logic [31:0] q; logic e; int lat;
        access(1'b1, 1'b0, 10'h010, 32'hDEAD_BEEF, 2'b10, 1'b0, q, e, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency: got %0d want 3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL store_err: got %b want 0", e); end
        access(1'b0, 1'b1, 10'h010, 32'd0, 2'b10, 1'b0, q, e, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency: got %0d want 3", lat); end
        checks++; if (q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_load: got %h want deadbeef", q); end
    endtask

    task automatic test_lanes();
        logic [31:0] q; logic e; int lat;
        access(1'b1, 1'b0, 10'h020, 32'h1122_3344, 2'b10, 1'b0, q, e, lat);
        access(1'b1, 1'b0, 10'h022, 32'h0000_00AA, 2'b00, 1'b0, q, e, lat);
        access(1'b0, 1'b1, 10'h020, 32'd0, 2'b10, 1'b0, q, e, lat);
        checks++; if (q !== 32'h11AA_3344) begin errors++; $display("FAIL byte_lane: got %h want 11aa3344", q); end
        access(1'b1, 1'b0, 10'h021, 32'h0000_BEEF, 2'b01, 1'b0, q, e, lat);
        access(1'b0, 1'b1, 10'h010, 32'd0, 2'b10, 1'b0, q, e, lat);
        checks++; if (q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL other_word: got %h want deadbeef", q); end
    endtask

    task automatic test_extend();
        logic [31:0] q; logic e; int lat;
        access(1'b1, 1'b0, 10'h020, 32'h1122_3344, 2'b10, 1'b0, q, e, lat);
        access(1'b1, 1'b0, 10'h022, 32'h0000_00AA, 2'b00, 1'b0, q, e, lat);
        access(1'b0, 1'b1, 10'h022, 32'd0, 2'b00, 1'b0, q, e, lat);
        checks++; if (q !== 32'hFFFF_FFAA) begin errors++; $display("FAIL byte_signed: got %h want ffffffaa", q); end
        access(1'b0, 1'b1, 10'h022, 32'd0, 2'b00, 1'b1, q, e, lat);
        checks++; if (q !== 32'h0000_00AA) begin errors++; $display("FAIL byte_unsigned: got %h want 000000aa", q); end
        access(1'b0, 1'b1, 10'h020, 32'd0, 2'b01, 1'b0, q, e, lat);
        checks++; if (q !== 32'h0000_3344) begin errors++; $display("FAIL half_low: got %h want 00003344", q); end
        access(1'b0, 1'b1, 10'h023, 32'd0, 2'b00, 1'b0, q, e, lat);
        checks++; if (q !== 32'h0000_0011) begin errors++; $display("FAIL byte_lane3: got %h want 00000011", q); end
        access(1'b0, 1'b1, 10'h022, 32'd0, 2'b01, 1'b0, q, e, lat);
        checks++; if (q !== 32'h0000_11AA) begin errors++; $display("FAIL half_signed: got %h want 000011aa", q); end
    endtask

    task automatic test_both_high();
        logic [31:0] q; logic e; int lat;
        access(1'b1, 1'b1, 10'h050, 32'h5A5A_1234, 2'b10, 1'b0, q, e, lat);
        checks++; if (q !== 32'h0000_11AA) begin errors++; $display("FAIL both_high_data: got %h want 000011aa", q); end
        access(1'b1, 1'b0, 10'h054, 32'h0000_8001, 2'b01, 1'b0, q, e, lat);
        access(1'b0, 1'b1, 10'h054, 32'd0, 2'b01, 1'b0, q, e, lat);
        checks++; if (q !== 32'hFFFF_8001) begin errors++; $display("FAIL half_neg: got %h want ffff8001", q); end
        access(1'b0, 1'b1, 10'h050, 32'd0, 2'b10, 1'b0, q, e, lat);
        checks++; if (q !== 32'h5A5A_1234) begin errors++; $display("FAIL both_high_store: got %h want 5a5a1234", q); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'hA000_0001; vals[1] = 32'hB000_0002;
        vals[2] = 32'hC000_0003; vals[3] = 32'hD000_0004;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            wr0 = (pass == 0); rd0 = (pass == 1); addr0 = 10'h100; wd0 = vals[0]; sz0 = 2'b10;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk);
                #1;
                if (k % 2 == 0) begin
                    if (k / 2 + 1 < 4) begin
                        addr0 = 10'h100 + 10'(4 * (k / 2 + 1));
                        wd0 = vals[k / 2 + 1];
                    end else begin
                        wr0 = 1'b0; rd0 = 1'b0;
                    end
                end
                @(negedge clk);
                checks++; if (ready0 !== (k % 2 == 1)) begin errors++; $display("FAIL b2b_ready pass%0d cyc%0d: got %b want %b", pass, k, ready0, (k % 2 == 1)); end
                checks++; if (busy0 !== (k % 2 == 0)) begin errors++; $display("FAIL b2b_busy pass%0d cyc%0d: got %b want %b", pass, k, busy0, (k % 2 == 0)); end
                if (pass == 1 && k % 2 == 1) begin
                    checks++; if (data0 !== vals[k / 2]) begin errors++; $display("FAIL b2b_data %0d: got %h want %h", k / 2, data0, vals[k / 2]); end
                end
            end
            @(negedge clk);
            checks++; if ({ready0, busy0} !== 2'b00) begin errors++; $display("FAIL b2b_idle pass%0d: got %b want 00", pass, {ready0, busy0}); end
        end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] q; logic e; int lat;
        logic saw_ready;
        access(1'b1, 1'b0, 10'h040, 32'h1234_5678, 2'b10, 1'b0, q, e, lat);
        access(1'b0, 1'b1, 10'h010, 32'd0, 2'b10, 1'b0, q, e, lat);
        @(negedge clk);
        wr = 1'b1; addr = 10'h040; wd = 32'h5555_5555; sz = 2'b10;
        @(posedge clk);
        #1;
        wr = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, ready, err} !== 3'b000) begin errors++; $display("FAIL mid_reset_flags: got %b want 000", {busy, ready, err}); end
        checks++; if (data !== 32'd0) begin errors++; $display("FAIL mid_reset_data: got %h want 00000000", data); end
        @(negedge clk);
        rst_n = 1'b1;
        saw_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ready) saw_ready = 1'b1;
        end
        checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL mid_no_ready: got %b want 0", saw_ready); end
        access(1'b0, 1'b1, 10'h040, 32'd0, 2'b10, 1'b0, q, e, lat);
        checks++; if (q !== 32'h1234_5678) begin errors++; $display("FAIL mid_not_committed: got %h want 12345678", q); end
    endtask

    task automatic test_misalign();
        logic [31:0] q; logic e; int lat;
        access(1'b1, 1'b0, 10'h030, 32'h0BAD_C0DE, 2'b10, 1'b0, q, e, lat);
        access(1'b1, 1'b0, 10'h031, 32'hCAFE_F00D, 2'b10, 1'b0, q, e, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL mis_latency: got %0d want 3", lat); end
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL mis_store_err: got %b want 1", e); end
        access(1'b0, 1'b1, 10'h030, 32'd0, 2'b10, 1'b0, q, e, lat);
        checks++; if (q !== 32'h0BAD_C0DE) begin errors++; $display("FAIL mis_store_suppressed: got %h want 0badc0de", q); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL aligned_err: got %b want 0", e); end
        access(1'b0, 1'b1, 10'h031, 32'd0, 2'b10, 1'b0, q, e, lat);
        checks++; if ({e, q} !== {1'b1, 32'd0}) begin errors++; $display("FAIL mis_load: got %b/%h want 1/00000000", e, q); end
`else
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL mis_store_err: got %b want 0", e); end
        access(1'b0, 1'b1, 10'h030, 32'd0, 2'b10, 1'b0, q, e, lat);
        checks++; if (q !== 32'hCAFE_F00D) begin errors++; $display("FAIL mis_store_aligned: got %h want cafef00d", q); end
        access(1'b0, 1'b1, 10'h033, 32'd0, 2'b01, 1'b0, q, e, lat);
        checks++; if ({e, q} !== {1'b0, 32'hFFFF_CAFE}) begin errors++; $display("FAIL mis_half_load: got %b/%h want 0/ffffcafe", e, q); end
`endif
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_extend();
        test_both_high();
        test_back_to_back();
        test_reset_mid_store();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
